// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU issue controller and its FIFO.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  localparam int FLG_NAN  = 3;
  localparam int FLG_INF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_SIGN = 0;

  localparam int ENTRY_W = 66;

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_e;

  // One queued operation: opcode plus both FP32 operands.
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_entry_t;

  // Classify an FP32 value; denormals are deliberately not reported as zero.
  function automatic logic [3:0] classify(input logic [31:0] r);
    logic [7:0]        e;
    logic [FRAC_W-1:0] f;
    logic [3:0]        fl;
    e  = r[EXP_MSB:EXP_LSB];
    f  = r[FRAC_W-1:0];
    fl = '0;
    fl[FLG_NAN]  = (e == EXP_ALL_ONES) && (f != '0);
    fl[FLG_INF]  = (e == EXP_ALL_ONES) && (f == '0);
    fl[FLG_ZERO] = (e == '0) && (f == '0);
    fl[FLG_SIGN] = r[SIGN_BIT];
    return fl;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Operand, FPU and result signals of the FPU issue controller.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the operand side, res_valid/res_ready on results.
interface fpu_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [1:0]    in_op;
  logic [31:0]   fpu_a;
  logic [31:0]   fpu_b;
  logic [1:0]    fpu_op;
  logic [31:0]   fpu_result;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [1:0]    res_op;
  logic [3:0]    res_flags;
  logic          busy;
  logic [AW:0]   count;

  modport slave (
    input  in_valid, in_a, in_b, in_op, fpu_result, res_ready,
    output in_ready, fpu_a, fpu_b, fpu_op, res_valid, res_data, res_op, res_flags,
           busy, count
  );

  modport master (
    output in_valid, in_a, in_b, in_op, fpu_result, res_ready,
    input  in_ready, fpu_a, fpu_b, fpu_op, res_valid, res_data, res_op, res_flags,
           busy, count
  );

endinterface

// File: rtl/fpu_op_fifo.sv
// Generic synchronous FIFO for queued operations; head is visible combinationally.
// Latency: a pushed entry is poppable the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no full-bypass.
module fpu_op_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, power-of-two wrapping pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Queues FP32 ops, drives them to the combinational FPU and returns classified results.
// Latency: push into idle empty block -> res_valid after SETTLE+1 further edges.
// Backpressure: in_ready drops when the FIFO is full; a result holds until res_ready.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input logic             clk,
  input logic             rst,
  fpu_issue_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        pop;
  logic        capture;
  logic        res_clr;
  logic        in_ready;
  op_entry_t   head;
  op_entry_t   tail;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  logic [31:0] fpu_a_q, fpu_b_q;
  logic [1:0]  fpu_op_q;
  logic        res_valid_q;
  logic [31:0] res_data_q;
  logic [1:0]  res_op_q;
  logic [3:0]  res_flags_q;

  assign tail     = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
  assign in_ready = !rst && !fifo_full;

  fpu_op_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (bus.in_valid && in_ready),
    .din_i  (tail),
    .pop_i  (pop),
    .dout_o (head),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Next state: fetch in IDLE, count down settle time in WAIT, hand off result in OUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    res_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = CW'(SETTLE);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          res_clr = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            cnt_d   = CW'(SETTLE);
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand registers change only when an entry leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a_q  <= '0;
      fpu_b_q  <= '0;
      fpu_op_q <= '0;
    end else if (pop) begin
      fpu_a_q  <= head.a;
      fpu_b_q  <= head.b;
      fpu_op_q <= head.op;
    end
  end

  // Result capture after settling; held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_flags_q <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bus.fpu_result;
      res_op_q    <= fpu_op_q;
      res_flags_q <= classify(bus.fpu_result);
    end else if (res_clr) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.fpu_a     = fpu_a_q;
  assign bus.fpu_b     = fpu_b_q;
  assign bus.fpu_op    = fpu_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_flags = res_flags_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;
  assign bus.count     = fifo_count;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl with a behavioural FPU stand-in and an in-order result model.
// Latency: not applicable.
// Backpressure: bench drives res_ready directly, including random stalls.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if #(.DEPTH(DEPTH)) bus();

  fpu_issue_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // FP32 <-> real helpers; denormal inputs are treated as zero by this stand-in FPU.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h00)      d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
    else                        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'h7FF) return (d[51:0] != 52'd0) ? {d[63], 8'hFF, 23'h400000} : {d[63], 8'hFF, 23'h0};
    if (e > 11'd1150) return {d[63], 8'hFF, 23'h0};
    if (e < 11'd897)  return {d[63], 31'h0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real ra, rb, rr;
    ra = f2r(a);
    rb = f2r(b);
    case (op)
      OP_ADD:  rr = ra + rb;
      OP_SUB:  rr = ra - rb;
      OP_MUL:  rr = ra * rb;
      default: rr = ra / rb;
    endcase
    return r2f(rr);
  endfunction

  function automatic logic [3:0] flags_of(input logic [31:0] r);
    return {(r[30:23] == 8'hFF) && (r[22:0] != 23'd0),
            (r[30:23] == 8'hFF) && (r[22:0] == 23'd0),
            r[30:0] == 31'd0,
            r[31]};
  endfunction

  assign bus.fpu_result = fpu_model(bus.fpu_a, bus.fpu_b, bus.fpu_op);

  // Reference model: results must come back in acceptance order.
  typedef struct {
    logic [31:0] d;
    logic [1:0]  op;
  } exp_t;
  exp_t        exp_q[$];
  int          delivered = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_op;
  logic [3:0]  prev_flags;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
      check_eq("in_ready_in_rst", bus.in_ready, 0);
    end else begin
      check_eq("busy", bus.busy, exp_q.size() != 0);
      if (hold_prev) begin
        check_eq("hold_valid", bus.res_valid, 1);
        check_eq("hold_data", bus.res_data, prev_data);
        check_eq("hold_op", bus.res_op, prev_op);
        check_eq("hold_flags", bus.res_flags, prev_flags);
      end
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("stale_result", bus.res_valid, 0);
        end else if (bus.res_ready) begin
          e = exp_q.pop_front();
          check_eq("res_data", bus.res_data, e.d);
          check_eq("res_op", bus.res_op, e.op);
          check_eq("res_flags", bus.res_flags, flags_of(e.d));
          delivered++;
        end
      end
      hold_prev  = bus.res_valid && !bus.res_ready;
      prev_data  = bus.res_data;
      prev_op    = bus.res_op;
      prev_flags = bus.res_flags;
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{d: fpu_model(bus.in_a, bus.in_b, bus.in_op), op: bus.in_op});
    end
  end

  logic [31:0] fp_tbl [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.in_a  = a;
    bus.in_b  = b;
    bus.in_op = op;
  endtask

  // Offer ops continuously with res_ready low; returns how many were taken.
  task automatic fill(output int acc);
    int idx;
    acc = 0;
    idx = 0;
    bus.res_ready = 1'b0;
    drive(fp_tbl[0], 32'h40000000, 2'(idx));
    bus.in_valid = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc++;
        step();
        idx++;
        drive(fp_tbl[idx % 6], 32'h40000000, 2'(idx));
      end else begin
        step();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drained"}, bus.busy, 0);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, output logic [31:0] d, output logic [3:0] f);
    logic got;
    got = 1'b0;
    d   = '0;
    f   = '0;
    step();
    drive(a, b, op);
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid && !got) begin
        d   = bus.res_data;
        f   = bus.res_flags;
        got = 1'b1;
      end
    end
    check_eq({tag, "_seen"}, got, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd [3];
    int          rc [3];
    int          n;
    int          acc;
    int          d0;
    int          vcnt;
    logic [31:0] d;
    logic [3:0]  f;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    drive('0, '0, '0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_fpu_a", bus.fpu_a, 0);
    check_eq("rst_res_data", bus.res_data, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);

    // Latency: 3.0 + 4.0
    step();
    bus.res_ready = 1'b1;
    drive(32'h40400000, 32'h40800000, OP_ADD);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk); check_eq("lat_edge0", bus.res_valid, 0);
    step();
    @(negedge clk); check_eq("lat_edge1", bus.res_valid, 0);
    step();
    @(negedge clk);
    check_eq("lat_edge2", bus.res_valid, 1);
    check_eq("lat_data", bus.res_data, 32'h40E00000);
    check_eq("lat_op", bus.res_op, 0);
    check_eq("lat_flags", bus.res_flags, 0);
    step();
    step();

    // Ordered back-to-back burst
    drive(32'h40C00000, 32'h40800000, OP_SUB);
    bus.in_valid = 1'b1;
    step();
    drive(32'h3F800000, 32'h40000000, OP_MUL);
    step();
    drive(32'h40400000, 32'h40000000, OP_DIV);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    rd = '{default: '0};
    rc = '{default: 0};
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready && n < 3) begin
        rd[n] = bus.res_data;
        rc[n] = k;
        n++;
      end
    end
    check_eq("burst_count", n, 3);
    check_eq("burst_r0", rd[0], 32'h40000000);
    check_eq("burst_r1", rd[1], 32'h40000000);
    check_eq("burst_r2", rd[2], 32'h3FC00000);
    check_eq("burst_gap01", rc[1] - rc[0], 2);
    check_eq("burst_gap12", rc[2] - rc[1], 2);

    // Flag classification
    run_one("inf", 32'h7F800000, 32'h3F800000, OP_ADD, d, f);
    check_eq("inf_data", d, 32'h7F800000);
    check_eq("inf_flags", f, 4'b0100);
    run_one("nan", 32'h7FC00000, 32'h3F800000, OP_MUL, d, f);
    check_eq("nan_flag", f[3], 1);
    check_eq("nan_exp", d[30:23], 8'hFF);
    run_one("zero", 32'h3F800000, 32'h3F800000, OP_SUB, d, f);
    check_eq("zero_data", d, 32'h00000000);
    check_eq("zero_flags", f, 4'b0010);
    run_one("neg", 32'hC0000000, 32'h3F800000, OP_MUL, d, f);
    check_eq("neg_data", d, 32'hC0000000);
    check_eq("neg_flags", f, 4'b0001);

    // Backpressure capacity and in-order drain
    step();
    fill(acc);
    @(negedge clk);
    check_eq("bp_accepted", acc, DEPTH + 1);
    check_eq("bp_in_ready", bus.in_ready, 0);
    check_eq("bp_count", bus.count, DEPTH);
    d0 = delivered;
    step();
    drain("bp");
    check_eq("bp_delivered", delivered - d0, DEPTH + 1);

    // Full FIFO while a pop happens: no bypass
    step();
    fill(acc);
    drive(32'h40A00000, 32'h40A00000, OP_ADD);
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_eq("fullpop_rdy", bus.in_ready, 0);
    check_eq("fullpop_count", bus.count, DEPTH);
    step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_eq("fullpop_rdy_next", bus.in_ready, 1);
    check_eq("fullpop_count_next", bus.count, DEPTH - 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("fullpop_count_after", bus.count, DEPTH);
    step();
    drain("fullpop");

    // Reset while WAIT with three queued
    step();
    fill(acc);
    bus.res_ready = 1'b1;
    step();
    rst           = 1'b1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_eq("midrst_pre_count", bus.count, 3);
    check_eq("midrst_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_res_valid", bus.res_valid, 0);
    check_eq("midrst_count", bus.count, 0);
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_fpu_a", bus.fpu_a, 0);
    check_eq("midrst_fpu_b", bus.fpu_b, 0);
    check_eq("midrst_fpu_op", bus.fpu_op, 0);
    bus.res_ready = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) vcnt++;
    end
    check_eq("midrst_no_stale", vcnt, 0);

    // Randomized traffic with stalls and occasional resets
    for (int c = 0; c < 600; c++) begin
      step();
      rst           = ($urandom_range(0, 149) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 6);
      bus.res_ready = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: drive(fp_tbl[$urandom_range(0, 5)], fp_tbl[$urandom_range(0, 5)], 2'($urandom_range(0, 3)));
        1: drive(32'h7F800000, {$urandom_range(0, 1) == 1, 31'h3F800000}, 2'($urandom_range(0, 3)));
        default: drive({$urandom_range(0, 1) == 1, 8'($urandom_range(100, 150)), 23'($urandom())},
                       {$urandom_range(0, 1) == 1, 8'($urandom_range(100, 150)), 23'($urandom())},
                       2'($urandom_range(0, 3)));
      endcase
    end
    step();
    rst = 1'b0;
    drain("rand");
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
